// File: rtl/vector_checker.sv
// vector_checker: replays stored stimulus vectors into a DUT and compares the
// sampled response against masked expected values, counting vectors and errors.
module vector_checker #(
  parameter int IN_W   = 3,
  parameter int OUT_W  = 1,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int LAT    = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_en,
  input  logic [ADDR_W-1:0]         load_addr,
  input  logic [IN_W+2*OUT_W-1:0]   load_data,
  input  logic [ADDR_W:0]           num_vec,
  input  logic                      start,
  input  logic                      abort,
  output logic [IN_W-1:0]           dut_in,
  input  logic [OUT_W-1:0]          dut_out,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [ADDR_W:0]           vec_count,
  output logic [ADDR_W:0]           err_count,
  output logic                      first_err_valid,
  output logic [ADDR_W-1:0]         first_err_idx,
  output logic [OUT_W-1:0]          first_err_got
);

  localparam int W = IN_W + 2*OUT_W;
  localparam int CNT_W = (LAT < 2) ? 1 : $clog2(LAT + 1);
  localparam logic [ADDR_W:0] NMAX = (ADDR_W+1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CHECK, DONE} state_t;

  state_t state, state_nxt;

  logic [W-1:0]      mem [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W:0]   n;
  logic [ADDR_W:0]   n_req;
  logic [CNT_W-1:0]  cnt;
  logic [W-1:0]      cur;
  logic [IN_W-1:0]   cur_stim;
  logic [OUT_W-1:0]  cur_exp;
  logic [OUT_W-1:0]  cur_care;
  logic              mismatch;
  logic              last;
  logic              abort_run;

  // Memory is read asynchronously so a write in the start cycle is seen by vector 0.
  assign cur       = mem[idx];
  assign cur_stim  = cur[W-1 -: IN_W];
  assign cur_exp   = cur[2*OUT_W-1 -: OUT_W];
  assign cur_care  = cur[OUT_W-1:0];
  assign mismatch  = |((dut_out ^ cur_exp) & cur_care);
  assign n_req     = (num_vec > NMAX) ? NMAX : num_vec;
  assign last      = ({1'b0, idx} == n - 1'b1);
  assign abort_run = abort & busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = (n_req == '0) ? DONE : DRIVE;
        end
      end
      DRIVE: begin
        if (abort) begin
          state_nxt = DONE;
        end else if (LAT > 0) begin
          state_nxt = WAIT;
        end else begin
          state_nxt = CHECK;
        end
      end
      WAIT: begin
        if (abort) begin
          state_nxt = DONE;
        end else if (cnt == CNT_W'(1)) begin
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (abort) begin
          state_nxt = DONE;
        end else if (last) begin
          state_nxt = DONE;
        end else begin
          state_nxt = DRIVE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      DRIVE, WAIT, CHECK: busy = 1'b1;
      DONE:               done = 1'b1;
      default: ;
    endcase
  end

  // Writes are dropped during a run so the vector set cannot shift under the checker.
  always_ff @(posedge clk) begin
    if (load_en && !busy && (int'(load_addr) < DEPTH)) begin
      mem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx             <= '0;
      n               <= '0;
      cnt             <= '0;
      dut_in          <= '0;
      pass            <= 1'b0;
      vec_count       <= '0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
      first_err_got   <= '0;
    end else if (abort_run) begin
      pass <= (err_count == '0);
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            idx             <= '0;
            n               <= n_req;
            pass            <= (n_req == '0);
            vec_count       <= '0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
            first_err_got   <= '0;
          end
        end
        DRIVE: begin
          dut_in <= cur_stim;
          cnt    <= CNT_W'(LAT);
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
        end
        CHECK: begin
          vec_count <= vec_count + 1'b1;
          if (mismatch) begin
            err_count <= err_count + 1'b1;
            if (!first_err_valid) begin
              first_err_valid <= 1'b1;
              first_err_idx   <= idx;
              first_err_got   <= dut_out;
            end
          end
          if (last) begin
            pass <= (err_count == '0) && !mismatch;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_checker.sv
// Bench for vector_checker: three instances (LAT 0, 2, 1) around majority DUTs,
// with a run-level scoreboard filled when a run is started and drained at done.
module tb_vector_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] load_sel;
  logic [3:0] load_addr;
  logic [4:0] load_data;
  logic [4:0] num_vec;
  logic [2:0] start_sel;
  logic       abort;

  logic [2:0] dut_in_a  [3];
  logic       dut_out_a [3];
  logic       busy_a    [3];
  logic       done_a    [3];
  logic       pass_a    [3];
  logic [4:0] vec_a     [3];
  logic [4:0] err_a     [3];
  logic       fev_a     [3];
  logic [3:0] fidx_a    [3];
  logic       fgot_a    [3];

  typedef struct {
    int vec;
    int err;
    int pass;
    int fev;
    int fidx;
    int fgot;
    int cyc;
  } exp_t;

  exp_t       sb [$];
  logic [2:0] m_stim [16];
  logic       m_exp  [16];
  logic       m_care [16];
  logic [2:0] last_stim [3];
  int         lat_of [3] = '{0, 2, 1};
  int         checks = 0;
  int         errors = 0;
  logic       p1a, p1b, p2a, p2b;

  always #5 clk = ~clk;

  function automatic logic maj(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  assign dut_out_a[0] = maj(dut_in_a[0]);
  assign dut_out_a[1] = p1b;
  assign dut_out_a[2] = p2b;

  always @(posedge clk) begin
    p1a <= maj(dut_in_a[1]);
    p1b <= p1a;
    p2a <= maj(dut_in_a[2]);
    p2b <= p2a;
  end

  vector_checker #(.IN_W(3), .OUT_W(1), .DEPTH(16), .ADDR_W(4), .LAT(0)) u0 (
    .clk(clk), .rst(rst), .load_en(load_sel[0]), .load_addr(load_addr),
    .load_data(load_data), .num_vec(num_vec), .start(start_sel[0]), .abort(abort),
    .dut_in(dut_in_a[0]), .dut_out(dut_out_a[0]), .busy(busy_a[0]), .done(done_a[0]),
    .pass(pass_a[0]), .vec_count(vec_a[0]), .err_count(err_a[0]),
    .first_err_valid(fev_a[0]), .first_err_idx(fidx_a[0]), .first_err_got(fgot_a[0]));

  vector_checker #(.IN_W(3), .OUT_W(1), .DEPTH(16), .ADDR_W(4), .LAT(2)) u1 (
    .clk(clk), .rst(rst), .load_en(load_sel[1]), .load_addr(load_addr),
    .load_data(load_data), .num_vec(num_vec), .start(start_sel[1]), .abort(abort),
    .dut_in(dut_in_a[1]), .dut_out(dut_out_a[1]), .busy(busy_a[1]), .done(done_a[1]),
    .pass(pass_a[1]), .vec_count(vec_a[1]), .err_count(err_a[1]),
    .first_err_valid(fev_a[1]), .first_err_idx(fidx_a[1]), .first_err_got(fgot_a[1]));

  vector_checker #(.IN_W(3), .OUT_W(1), .DEPTH(16), .ADDR_W(4), .LAT(1)) u2 (
    .clk(clk), .rst(rst), .load_en(load_sel[2]), .load_addr(load_addr),
    .load_data(load_data), .num_vec(num_vec), .start(start_sel[2]), .abort(abort),
    .dut_in(dut_in_a[2]), .dut_out(dut_out_a[2]), .busy(busy_a[2]), .done(done_a[2]),
    .pass(pass_a[2]), .vec_count(vec_a[2]), .err_count(err_a[2]),
    .first_err_valid(fev_a[2]), .first_err_idx(fidx_a[2]), .first_err_got(fgot_a[2]));

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic loadEntry(input logic [2:0] mask, input int a, input logic [2:0] s,
                           input logic e, input logic c, input bit upd);
    load_sel  = mask;
    load_addr = 4'(a);
    load_data = {s, e, c};
    @(negedge clk);
    load_sel = 3'b000;
    if (upd) begin
      m_stim[a] = s;
      m_exp[a]  = e;
      m_care[a] = c;
    end
  endtask

  task automatic loadTable(input logic [2:0] mask);
    for (int i = 0; i < 16; i++) begin
      logic [2:0] s;
      s = 3'(i);
      loadEntry(mask, i, s, maj(s), 1'b1, 1'b1);
    end
  endtask

  // Model: LAT-matched DUTs see maj(stim); the LAT=1 instance sees the previous vector.
  task automatic modelRun(input int k, input int nv);
    exp_t e;
    int   n;
    logic got, mm;
    n = (nv > 16) ? 16 : nv;
    e = '{vec: 0, err: 0, pass: 0, fev: 0, fidx: 0, fgot: 0, cyc: n * (lat_of[k] + 2)};
    for (int i = 0; i < n; i++) begin
      if (k == 2) got = (i == 0) ? maj(last_stim[k]) : maj(m_stim[i-1]);
      else        got = maj(m_stim[i]);
      mm = (got ^ m_exp[i]) & m_care[i];
      e.vec++;
      if (mm) begin
        e.err++;
        if (e.fev == 0) begin
          e.fev  = 1;
          e.fidx = i;
          e.fgot = int'(got);
        end
      end
    end
    e.pass = (e.err == 0) ? 1 : 0;
    if (n > 0) last_stim[k] = m_stim[n-1];
    sb.push_back(e);
  endtask

  task automatic startRun(input int k, input int nv);
    start_sel[k] = 1'b1;
    num_vec      = 5'(nv);
    @(negedge clk);
    start_sel = 3'b000;
  endtask

  task automatic applyStimulus(input int k, input int nv);
    modelRun(k, nv);
    startRun(k, nv);
  endtask

  task automatic waitDone(input int k);
    exp_t e;
    int   cyc = 0;
    int   guard = 0;
    while (!done_a[k] && guard < 2000) begin
      if (busy_a[k]) cyc++;
      guard++;
      @(negedge clk);
    end
    if (!done_a[k]) checkOutput("done_timeout", 0, 1);
    if (sb.size() == 0) begin
      checkOutput("scoreboard_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      checkOutput("busy_cycles", cyc, e.cyc);
      checkOutput("vec_count", vec_a[k], e.vec);
      checkOutput("err_count", err_a[k], e.err);
      checkOutput("pass", pass_a[k], e.pass);
      checkOutput("first_err_valid", fev_a[k], e.fev);
      checkOutput("busy_at_done", busy_a[k], 0);
      if (e.fev != 0) begin
        checkOutput("first_err_idx", fidx_a[k], e.fidx);
        checkOutput("first_err_got", fgot_a[k], e.fgot);
      end
    end
  endtask

  task automatic checkReset(input int k);
    checkOutput("rst_busy", busy_a[k], 0);
    checkOutput("rst_done", done_a[k], 0);
    checkOutput("rst_pass", pass_a[k], 0);
    checkOutput("rst_vec", vec_a[k], 0);
    checkOutput("rst_err", err_a[k], 0);
    checkOutput("rst_fev", fev_a[k], 0);
    checkOutput("rst_fidx", fidx_a[k], 0);
    checkOutput("rst_fgot", fgot_a[k], 0);
    checkOutput("rst_dut_in", dut_in_a[k], 0);
  endtask

  initial begin
    exp_t ab;
    rst       = 1'b1;
    load_sel  = 3'b000;
    load_addr = '0;
    load_data = '0;
    num_vec   = '0;
    start_sel = 3'b000;
    abort     = 1'b0;
    for (int k = 0; k < 3; k++) last_stim[k] = 3'b000;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) checkReset(k);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] truth table, combinational DUT");
    loadTable(3'b111);
    applyStimulus(0, 8);
    waitDone(0);

    $display("[TB] bad expected on entry 5, then masked");
    loadEntry(3'b001, 5, 3'b101, 1'b0, 1'b1, 1'b1);
    applyStimulus(0, 8);
    waitDone(0);
    loadEntry(3'b001, 5, 3'b101, 1'b0, 1'b0, 1'b1);
    applyStimulus(0, 8);
    waitDone(0);
    loadEntry(3'b001, 5, 3'b101, 1'b1, 1'b1, 1'b1);

    $display("[TB] pipelined DUT, LAT 2 and LAT 1");
    applyStimulus(1, 8);
    waitDone(1);
    applyStimulus(2, 8);
    waitDone(2);

    $display("[TB] abort at 5th edge after start");
    ab = '{vec: 2, err: 0, pass: 1, fev: 0, fidx: 0, fgot: 0, cyc: 5};
    sb.push_back(ab);
    startRun(0, 8);
    fork
      waitDone(0);
      begin
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
      end
    join

    $display("[TB] reset mid-run");
    startRun(0, 8);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkReset(0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) last_stim[k] = 3'b000;
    @(negedge clk);
    applyStimulus(0, 8);
    waitDone(0);

    $display("[TB] load and start in the same cycle");
    m_exp[0] = 1'b1;
    modelRun(0, 1);
    load_sel     = 3'b001;
    load_addr    = 4'd0;
    load_data    = {3'b000, 1'b1, 1'b1};
    start_sel[0] = 1'b1;
    num_vec      = 5'd1;
    @(negedge clk);
    load_sel  = 3'b000;
    start_sel = 3'b000;
    waitDone(0);
    loadEntry(3'b001, 0, 3'b000, 1'b0, 1'b1, 1'b1);

    $display("[TB] num_vec 0 and clamp");
    applyStimulus(0, 0);
    waitDone(0);
    applyStimulus(0, 20);
    waitDone(0);

    $display("[TB] load during busy is dropped");
    applyStimulus(0, 8);
    fork
      waitDone(0);
      begin
        repeat (2) @(negedge clk);
        loadEntry(3'b001, 2, 3'b010, 1'b1, 1'b1, 1'b0);
      end
    join
    applyStimulus(0, 8);
    waitDone(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_checker.md
Name: vector_checker

Overview:
- Synthesizable, parametrised self-checking vector engine. It applies stored stimulus vectors to a DUT, samples the DUT output after a programmable latency, and compares it against masked expected values.
- Counts vectors and errors, and captures the first failing vector.
- Replaces file-driven simulation checking, so the same vector set runs on-chip or in any bench. Sits beside the DUT in a test wrapper.

Parameters:
- IN_W, 3, DUT input width (stimulus field).
- OUT_W, 1, DUT output width (expected and care fields).
- DEPTH, 16, vector memory entries.
- ADDR_W, 4, index width; must equal clog2(DEPTH).
- LAT, 0, extra wait cycles between driving stimulus and sampling dut_out (0 = combinational DUT).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- load_en  in  1  write vector memory (ignored while busy).
- load_addr  in  ADDR_W  write address.
- load_data  in  IN_W+2*OUT_W  vector word {stim[IN_W], exp[OUT_W], care[OUT_W]}, stim in MSBs.
- num_vec  in  ADDR_W+1  vectors to run, sampled at start; values >DEPTH clamp to DEPTH.
- start  in  1  begin run (accepted in IDLE or DONE).
- abort  in  1  terminate run early.
- dut_in  out  IN_W  registered stimulus to DUT.
- dut_out  in  OUT_W  DUT response.
- busy  out  1  run in progress.
- done  out  1  run finished; held until start or rst.
- pass  out  1  valid when done: err_count==0.
- vec_count  out  ADDR_W+1  vectors checked.
- err_count  out  ADDR_W+1  mismatching vectors.
- first_err_valid  out  1  at least one error captured.
- first_err_idx  out  ADDR_W  index of first failing vector.
- first_err_got  out  OUT_W  dut_out sampled at first failure.

Behaviour:
- Reset values:
  - State IDLE; all outputs 0.
  - Vector memory is not reset; contents are undefined until loaded.
  - rst mid-run aborts immediately and does not touch memory.
- FSM states: IDLE, DRIVE, WAIT, CHECK, DONE. busy=1 in DRIVE/WAIT/CHECK. done=1 only in DONE.
- IDLE/DONE, start=1:
  - Clear vec_count, err_count, first_err_*, done, pass.
  - idx<=0; n<=min(num_vec,DEPTH).
  - If n==0, go to DONE with pass=1. Otherwise go to DRIVE.
- DRIVE: dut_in<=mem[idx].stim; wait counter<=LAT. Go to WAIT if LAT>0, else CHECK.
- WAIT: decrement counter; go to CHECK when it reaches 1.
- CHECK (compare on the leaving edge):
  - mismatch = |((dut_out ^ exp) & care).
  - vec_count+1.
  - On mismatch: err_count+1. If first_err_valid==0, capture idx and dut_out and set first_err_valid.
  - If idx==n-1, go to DONE with pass=(final err_count==0). Otherwise idx+1 and go to DRIVE.
- Per-vector cost: LAT+2 cycles. DONE is entered N*(LAT+2) edges after the start edge.
- abort=1 in DRIVE/WAIT/CHECK:
  - Go to DONE on that edge; the vector in flight is not counted.
  - pass = (err_count==0) over the checked vectors.
  - abort has priority over the CHECK compare in the same cycle.
- dut_in holds its last value in DONE/IDLE.
- start while busy is ignored; abort in IDLE/DONE is ignored.
- load_en while busy is dropped; memory is unchanged.
- load_en and start in the same IDLE cycle: the write completes and the run starts. Vector 0 is read at DRIVE, so it sees the new data.
- Counters cannot overflow: max value is DEPTH, which fits in ADDR_W+1 bits.

Test Plan:
Bench DUT: dut_out=majority(dut_in) combinational unless stated. Defaults apply.
1. Load the 8-entry majority truth table, care=1, num_vec=8, start.
   -> busy high 16 cycles; done=1, pass=1, vec_count=8, err_count=0, first_err_valid=0.
2. Same, but entry 5 (stim 101) has exp=0.
   -> err_count=1, first_err_idx=5, first_err_got=1, pass=0.
   Then set care=0 on entry 5 and restart -> pass=1.
3. Set LAT=2 with a 2-register pipelined majority DUT, 8 vectors.
   -> 32 cycles busy, pass=1.
   Same run with LAT=1 -> err_count>0, pass=0.
4. Assert abort in the cycle sampled at the 5th edge after start.
   -> DONE next edge, vec_count=2, busy=0, done=1.
   Assert rst mid-run in a separate run -> all outputs 0 the next cycle; memory intact, a rerun passes.
5. num_vec=0 -> done=1, pass=1, vec_count=0 one edge after start.
   num_vec=20 -> clamps, vec_count=16.
6. load_en during busy with a bad exp value -> ignored; the current and next runs still pass.
